// File: rtl/seven_seg_pkg.sv
// Shared constants for the multiplexed 7-segment display bus.
// Segment patterns are active low in {g,f,e,d,c,b,a} order.
package seven_seg_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_HEX [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational reverse lookup from an active-low segment pattern to a hex nibble.
// Any pattern that is neither hex nor blank leaves both flags low.
module seg7_pattern_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       is_hex,
    output logic       is_blank
);

    always_comb begin
        nibble   = '0;
        is_hex   = 1'b0;
        is_blank = (seg == SEG_BLANK);
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_HEX[i]) begin
                nibble = 4'(i);
                is_hex = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seven_seg_scan_capture.sv
// Receiver for the multiplexed an/seg display bus: qualifies each stable dwell,
// decodes it per digit position and rebuilds the 8-digit value.
module seven_seg_scan_capture
    import seven_seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic [6:0]              seg,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    commit_stb,
    output logic [2:0]              commit_idx,
    output logic                    frame_done,
    output logic                    anode_err,
    output logic                    seg_err
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 2);

    logic [NUM_DIGITS-1:0] an_q, an_p;
    logic [6:0]            seg_q, seg_p;
    logic [CNT_W-1:0]      cnt;
    logic [NUM_DIGITS-1:0] frame_mask;

    logic                  same;
    logic                  commit_now;
    logic                  an_idle;
    logic                  an_onehot;
    logic [NUM_DIGITS-1:0] an_low;
    logic [2:0]            an_idx;
    logic [NUM_DIGITS-1:0] mask_next;
    logic [3:0]            nibble;
    logic                  is_hex;
    logic                  is_blank;

    seg7_pattern_decode u_decode (
        .seg      (seg_q),
        .nibble   (nibble),
        .is_hex   (is_hex),
        .is_blank (is_blank)
    );

    // A dwell commits exactly once: on the cycle the counter steps onto its saturation value.
    always_comb begin
        same       = (an_q == an_p) && (seg_q == seg_p);
        commit_now = same && (cnt == CNT_LAST);
        an_idle    = (an_q == '1);
        an_low     = ~an_q;
        an_onehot  = (an_low != '0) && ((an_low & (an_low - 1'b1)) == '0);
        an_idx     = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_q[i]) begin
                an_idx = 3'(i);
            end
        end
        mask_next  = frame_mask | (NUM_DIGITS'(1) << an_idx);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_q  <= '1;
            seg_q <= SEG_BLANK;
            an_p  <= '1;
            seg_p <= SEG_BLANK;
            cnt   <= '0;
        end else begin
            an_q  <= an;
            seg_q <= seg;
            an_p  <= an_q;
            seg_p <= seg_q;
            if (!same) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Blank anodes are a legal gap in the scan; several active anodes are a bus fault.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digits      <= '0;
            digit_valid <= '0;
            commit_stb  <= 1'b0;
            commit_idx  <= '0;
            frame_done  <= 1'b0;
            anode_err   <= 1'b0;
            seg_err     <= 1'b0;
            frame_mask  <= '0;
        end else begin
            commit_stb <= 1'b0;
            frame_done <= 1'b0;
            anode_err  <= 1'b0;
            seg_err    <= 1'b0;
            if (commit_now && !an_idle) begin
                if (!an_onehot) begin
                    anode_err <= 1'b1;
                end else begin
                    commit_stb <= 1'b1;
                    commit_idx <= an_idx;
                    if (is_hex) begin
                        digits[{an_idx, 2'b00} +: 4] <= nibble;
                        digit_valid[an_idx]          <= 1'b1;
                    end else if (is_blank) begin
                        digits[{an_idx, 2'b00} +: 4] <= 4'h0;
                        digit_valid[an_idx]          <= 1'b0;
                    end else begin
                        seg_err             <= 1'b1;
                        digit_valid[an_idx] <= 1'b0;
                    end
                    if (mask_next == '1) begin
                        frame_done <= 1'b1;
                        frame_mask <= '0;
                    end else begin
                        frame_mask <= mask_next;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_capture.sv
// Scoreboard bench for seven_seg_scan_capture: directed dwells push expected
// events, a negedge monitor pops and compares whenever the DUT pulses.
module tb_seven_seg_scan_capture;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic [31:0] digits;
    logic [7:0]  digit_valid;
    logic        commit_stb;
    logic [2:0]  commit_idx;
    logic        frame_done;
    logic        anode_err;
    logic        seg_err;

    typedef struct {
        int          when;
        bit          c;
        logic [2:0]  idx;
        bit          fd;
        bit          ae;
        bit          se;
        logic [31:0] dg;
        logic [7:0]  dv;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    seven_seg_scan_capture #(.STABLE_CYCLES(S), .CNT_W(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .an          (an),
        .seg         (seg),
        .digits      (digits),
        .digit_valid (digit_valid),
        .commit_stb  (commit_stb),
        .commit_idx  (commit_idx),
        .frame_done  (frame_done),
        .anode_err   (anode_err),
        .seg_err     (seg_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_digits"}, digits, 32'h0);
        checkOutput({tag, "_valid"}, 32'(digit_valid), 32'h0);
        checkOutput({tag, "_stb"}, 32'(commit_stb), 32'h0);
        checkOutput({tag, "_idx"}, 32'(commit_idx), 32'h0);
        checkOutput({tag, "_frame"}, 32'(frame_done), 32'h0);
        checkOutput({tag, "_aerr"}, 32'(anode_err), 32'h0);
        checkOutput({tag, "_serr"}, 32'(seg_err), 32'h0);
    endtask

    task automatic pushExpect(input bit c, input logic [2:0] idx, input bit fd, input bit ae,
                              input bit se, input logic [31:0] dg, input logic [7:0] dv);
        exp_t e;
        e.when = cyc + 1 + S;
        e.c    = c;
        e.idx  = idx;
        e.fd   = fd;
        e.ae   = ae;
        e.se   = se;
        e.dg   = dg;
        e.dv   = dv;
        sbq.push_back(e);
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [6:0] s, input int hold,
                                 input bit ev, input bit c, input logic [2:0] idx,
                                 input bit fd, input bit ae, input bit se,
                                 input logic [31:0] dg, input logic [7:0] dv);
        @(negedge clk);
        an  = a;
        seg = s;
        if (ev) pushExpect(c, idx, fd, ae, se, dg, dv);
        repeat (hold - 1) @(negedge clk);
    endtask

    // Any pulse on the event outputs must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && (commit_stb || frame_done || anode_err || seg_err)) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_event: stb=%b aerr=%b serr=%b frame=%b at cycle %0d, expected none",
                         commit_stb, anode_err, seg_err, frame_done, cyc);
            end else begin
                e = sbq.pop_front();
                checkOutput("when", 32'(cyc), 32'(e.when));
                checkOutput("commit_stb", 32'(commit_stb), 32'(e.c));
                checkOutput("frame_done", 32'(frame_done), 32'(e.fd));
                checkOutput("anode_err", 32'(anode_err), 32'(e.ae));
                checkOutput("seg_err", 32'(seg_err), 32'(e.se));
                checkOutput("digits", digits, e.dg);
                checkOutput("digit_valid", 32'(digit_valid), 32'(e.dv));
                if (e.c) checkOutput("commit_idx", 32'(commit_idx), 32'(e.idx));
            end
        end
    end

    initial begin
        reset = 1'b1;
        an    = 8'hFE;
        seg   = 7'h79;
        repeat (3) @(negedge clk);
        checkIdle("reset");

        // Digit "1" held through reset release on the rightmost position
        reset = 1'b0;
        pushExpect(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 8'h01);
        repeat (12) @(negedge clk);

        // Scan 12345678 rightmost first; frame completes on index 7
        applyStimulus(8'hFE, 7'h00, 6, 1, 1, 3'd0, 0, 0, 0, 32'h0000_0008, 8'h01);
        applyStimulus(8'hFD, 7'h78, 6, 1, 1, 3'd1, 0, 0, 0, 32'h0000_0078, 8'h03);
        applyStimulus(8'hFB, 7'h02, 6, 1, 1, 3'd2, 0, 0, 0, 32'h0000_0678, 8'h07);
        applyStimulus(8'hF7, 7'h12, 6, 1, 1, 3'd3, 0, 0, 0, 32'h0000_5678, 8'h0F);
        applyStimulus(8'hEF, 7'h19, 6, 1, 1, 3'd4, 0, 0, 0, 32'h0004_5678, 8'h1F);
        applyStimulus(8'hDF, 7'h30, 6, 1, 1, 3'd5, 0, 0, 0, 32'h0034_5678, 8'h3F);
        applyStimulus(8'hBF, 7'h24, 6, 1, 1, 3'd6, 0, 0, 0, 32'h0234_5678, 8'h7F);
        applyStimulus(8'h7F, 7'h79, 6, 1, 1, 3'd7, 1, 0, 0, 32'h1234_5678, 8'hFF);

        // Glitching bus: pair changes every 2 clocks, nothing may commit
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) applyStimulus(8'hFE, 7'h24, 2, 0, 0, 3'd0, 0, 0, 0, 32'h0, 8'h0);
            else            applyStimulus(8'hFD, 7'h30, 2, 0, 0, 3'd0, 0, 0, 0, 32'h0, 8'h0);
        end
        checkOutput("glitch_digits", digits, 32'h1234_5678);
        checkOutput("glitch_valid", 32'(digit_valid), 32'h0000_00FF);

        // Two anodes low, then a blank digit on index 3
        applyStimulus(8'hFC, 7'h79, 6, 1, 0, 3'd0, 0, 1, 0, 32'h1234_5678, 8'hFF);
        applyStimulus(8'hF7, 7'h7F, 6, 1, 1, 3'd3, 0, 0, 0, 32'h1234_0678, 8'hF7);

        // Illegal segment pattern on index 4 keeps the old nibble
        applyStimulus(8'hEF, 7'h55, 6, 1, 1, 3'd4, 0, 0, 1, 32'h1234_0678, 8'hE7);

        // All anodes off is a quiet gap
        applyStimulus(8'hFF, 7'h7F, 8, 0, 0, 3'd0, 0, 0, 0, 32'h0, 8'h0);

        // Reset in the middle of a dwell on index 5
        @(negedge clk);
        an  = 8'hDF;
        seg = 7'h12;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1 checkIdle("midreset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        pushExpect(1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 32'h0050_0000, 8'h20);
        repeat (12) @(negedge clk);

        checkOutput("scoreboard_drained", 32'(sbq.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
